sdio_resp_rx: RTL and testbench
===============================

// Module: sdio_resp_rx
// PURPOSE
//  Receives the SD card's response frame on the CMD line after the command transmitter finishes sending a command.
//  Supported frames: 48-bit (R1/R1b/R6/R7, CRC-checked), 48-bit R3 (no CRC check) and 136-bit R2 (CID/CSD).
//  Detects the start bit, shifts in the frame and checks CRC7 (x^7+x^3+1) and the end bit.
//  Times out if no start bit arrives. Results go to the SD init/read controller.
// PARAMETERS
//  NCR_MAX      64   max sdio_clk rising edges to wait for the start bit before timeout
// PORTS
//  clk          in   1    system clock; sdio_clk is derived from it (at least 2 clk per sdio_clk)
//  rst_n        in   1    asynchronous, active-low reset
//  sdio_clk     in   1    SD clock level, synchronous to clk; rising edge = CMD sample point
//  sdio_cmd_i   in   1    CMD line input (the transmitter has released the line)
//  i_en         in   1    1-clk start pulse, issued when the transmitter's busy flag falls
//  i_resp_type  in   2    0 none, 1 48-bit CRC, 2 48-bit no CRC (R3), 3 136-bit R2
//  o_busy       out  1    high from accepted i_en until o_done
//  o_done       out  1    1-clk pulse: response complete (or timeout / none)
//  o_timeout    out  1    no start bit within NCR_MAX edges
//  o_crc_err    out  1    CRC7 mismatch (types 1 and 3 only)
//  o_frame_err  out  1    transmission bit != 0 or end bit != 1
//  o_resp_idx   out  6    bits[45:40] of a 48-bit frame; 6'h3F for R2
//  o_resp_arg   out  32   bits[39:8] of a 48-bit frame
//  o_resp_r2    out  120  R2 bits[127:8] (CID/CSD without CRC), MSB first
// BEHAVIOUR
//  Reset: o_busy=0, o_done=0, all error flags=0, o_resp_*=0, state=IDLE, counters=0.
//  Edge detect: register sdio_clk; rise = (sdio_clk_q==0 && sdio_clk==1). Sample sdio_cmd_i on the rise cycle.
//  States:
//   IDLE: on i_en (ignored while busy), latch i_resp_type, clear flags, set o_busy.
//     type 0: go to DONE. Otherwise: clear CRC, wait_cnt=0, go to WAIT_START.
//   WAIT_START: on each rise:
//     sample==0: this is the start bit (frame bit N-1); feed it to the CRC, bit_cnt=N-2, go to RECV.
//     otherwise wait_cnt++. Reaching wait_cnt==NCR_MAX sets o_timeout and goes to DONE.
//   RECV: on each rise, shift the sample into a 136-bit shift register, then:
//     CRC feed: 48-bit frames feed bits 47..8; R2 feeds bits 127..8 (start, transmission and reserved bits excluded).
//     Decrement bit_cnt. Sampling bit 0 (end bit) goes to CHECK.
//   CHECK (1 clk): set error flags and load outputs.
//     o_crc_err: received bits[7:1] != CRC (type 2 never sets it).
//     o_frame_err: transmission bit != 0, or end bit != 1.
//     Load o_resp_idx, o_resp_arg or o_resp_r2. Go to DONE.
//   DONE (1 clk): o_done=1, o_busy=0, go to IDLE.
//  Latency: o_done rises 2 clk after the rise that sampled the end bit. Type 0: o_done 2 clk after i_en.
//  Outputs and flags hold until the next accepted i_en; errors do not block new requests.
//  CRC register: 7 bits, serial, feedback = crc[6]^bit. Taps: next crc[0]=fb, crc[3]=crc[2]^fb, other bits shift up.
//  Simultaneous i_en and rise in IDLE: accept i_en; the rise is not sampled.
//  rst_n low mid-frame: immediate return to reset values, with no o_done pulse.
//  NCR_MAX counts rises, not clk cycles. The counter is wide enough for NCR_MAX and does not wrap.
// TESTING
//  1. Type 1, card sends idx=8, arg=32'h000001AA with correct CRC (bench CRC7 model) after 5 idle edges
//     -> o_done once; idx 8, arg 1AA; all flags 0.
//  2. Same frame with one CRC bit flipped -> o_crc_err=1, o_frame_err=0; idx and arg still loaded.
//  3. Type 1, CMD held high -> o_timeout=1 exactly on the 64th rise + 1 clk; o_done once; busy then drops.
//  4. Type 3, R2 with CSD 120'h00_2600_325B_5A83_AFFF_FFFF_8000_0A or similar plus correct CRC -> o_resp_r2 matches; no errors.
//  5. Type 2 (R3), arg=32'h80FF8000, CRC bits 7'h7F -> no o_crc_err. End bit forced 0 -> o_frame_err=1.
//  6. rst_n pulsed mid-RECV, then a fresh type-1 request -> clean reset values; second response correct.

Source files
------------

// File: rtl/sdio_resp_rx.sv
// sdio_resp_rx: receives the SD card's 48/136-bit response on CMD, checks
// CRC7/framing, times out after NCR_MAX sdio_clk rises without a start bit.
// Ports: clk/rst_n; sdio_clk level and sdio_cmd_i line sampled on sdio_clk rise;
// i_en/i_resp_type start a receive; o_busy/o_done status; o_timeout,
// o_crc_err, o_frame_err flags; o_resp_idx/o_resp_arg (48-bit), o_resp_r2 (R2).
module sdio_resp_rx #(
  parameter int NCR_MAX = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sdio_clk,
  input  logic         sdio_cmd_i,
  input  logic         i_en,
  input  logic [1:0]   i_resp_type,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_timeout,
  output logic         o_crc_err,
  output logic         o_frame_err,
  output logic [5:0]   o_resp_idx,
  output logic [31:0]  o_resp_arg,
  output logic [119:0] o_resp_r2
);

  localparam int WW = $clog2(NCR_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_START, RECV, CHECK, DONE
  } state_e;

  state_e         state_q, state_d;
  logic           sclk_q;
  logic [1:0]     type_q, type_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [7:0]     bit_q, bit_d;
  logic [6:0]     crc_q, crc_d;
  logic [134:0]   sr_q, sr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           to_q, to_d;
  logic           cerr_q, cerr_d;
  logic           ferr_q, ferr_d;
  logic [5:0]     idx_q, idx_d;
  logic [31:0]    arg_q, arg_d;
  logic [119:0]   r2_q, r2_d;

  logic           rise, fb, is_r2, feed;
  logic [6:0]     crc_nx;
  logic           unused_bits;

  assign rise   = ~sclk_q & sdio_clk;
  assign fb     = crc_q[6] ^ sdio_cmd_i;
  assign crc_nx = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
  assign is_r2  = (type_q == 2'd3);
  // R2 leaves its transmission and reserved bits out of the CRC
  assign feed   = (bit_q >= 8'd8) && (!is_r2 || bit_q <= 8'd127);

  // reserved bits of R2 are shifted through but never checked
  assign unused_bits = ^sr_q[133:128];

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    wait_d  = wait_q;
    bit_d   = bit_q;
    crc_d   = crc_q;
    sr_d    = sr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    to_d    = to_q;
    cerr_d  = cerr_q;
    ferr_d  = ferr_q;
    idx_d   = idx_q;
    arg_d   = arg_q;
    r2_d    = r2_q;
    unique case (state_q)
      IDLE: begin
        if (i_en) begin
          type_d = i_resp_type;
          to_d   = 1'b0;
          cerr_d = 1'b0;
          ferr_d = 1'b0;
          busy_d = 1'b1;
          crc_d  = '0;
          wait_d = '0;
          // type 0 spends the CHECK slot idle so o_done lands 2 clk after i_en
          state_d = (i_resp_type == 2'd0) ? CHECK : WAIT_START;
        end
      end
      WAIT_START: begin
        if (rise) begin
          if (!sdio_cmd_i) begin
            sr_d = {sr_q[133:0], sdio_cmd_i};
            if (!is_r2) crc_d = crc_nx;
            bit_d   = is_r2 ? 8'd134 : 8'd46;
            state_d = RECV;
          end else begin
            wait_d = wait_q + 1'b1;
            if (wait_d == WW'(NCR_MAX)) begin
              to_d    = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      RECV: begin
        if (rise) begin
          sr_d = {sr_q[133:0], sdio_cmd_i};
          if (feed) crc_d = crc_nx;
          bit_d = bit_q - 8'd1;
          if (bit_q == 8'd0) state_d = CHECK;
        end
      end
      CHECK: begin
        if (type_q != 2'd0) begin
          ferr_d = ~sr_q[0] | (is_r2 ? sr_q[134] : sr_q[46]);
          cerr_d = (type_q != 2'd2) && (sr_q[7:1] != crc_q);
          if (is_r2) begin
            idx_d = 6'h3F;
            r2_d  = sr_q[127:8];
          end else begin
            idx_d = sr_q[45:40];
            arg_d = sr_q[39:8];
          end
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == DONE) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sclk_q  <= 1'b0;
      type_q  <= '0;
      wait_q  <= '0;
      bit_q   <= '0;
      crc_q   <= '0;
      sr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      cerr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      idx_q   <= '0;
      arg_q   <= '0;
      r2_q    <= '0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sdio_clk;
      type_q  <= type_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      crc_q   <= crc_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      to_q    <= to_d;
      cerr_q  <= cerr_d;
      ferr_q  <= ferr_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
      r2_q    <= r2_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_timeout   = to_q;
  assign o_crc_err   = cerr_q;
  assign o_frame_err = ferr_q;
  assign o_resp_idx  = idx_q;
  assign o_resp_arg  = arg_q;
  assign o_resp_r2   = r2_q;

endmodule

// File: tb/tb_sdio_resp_rx.sv
// tb_sdio_resp_rx: randomized scoreboard bench for sdio_resp_rx.
// A card model drives CMD frames; a monitor checks every o_done.
`timescale 1ns/1ps
module tb_sdio_resp_rx;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sdio_clk = 1'b0;
  logic         sdio_cmd_i = 1'b1;
  logic         i_en = 1'b0;
  logic [1:0]   i_resp_type = 2'd0;
  logic         o_busy, o_done, o_timeout, o_crc_err, o_frame_err;
  logic [5:0]   o_resp_idx;
  logic [31:0]  o_resp_arg;
  logic [119:0] o_resp_r2;

  sdio_resp_rx #(.NCR_MAX(64)) dut (
    .clk(clk), .rst_n(rst_n), .sdio_clk(sdio_clk),
    .sdio_cmd_i(sdio_cmd_i), .i_en(i_en), .i_resp_type(i_resp_type),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
    .o_crc_err(o_crc_err), .o_frame_err(o_frame_err),
    .o_resp_idx(o_resp_idx), .o_resp_arg(o_resp_arg),
    .o_resp_r2(o_resp_r2)
  );

  always #5 clk = ~clk;

  // sdio_clk = clk/4
  initial forever begin
    repeat (2) @(posedge clk);
    #1 sdio_clk = ~sdio_clk;
  end

  typedef bit bq_t[$];
  typedef struct {
    int         kind;   // 0 none, 1 frame, 2 timeout
    bit         to, ce, fe;
    bit         chk_idx, chk_arg, chk_r2;
    bit [5:0]   idx;
    bit [31:0]  arg;
    bit [119:0] r2;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // CRC7 by polynomial long division, x^7+x^3+1
  function automatic bit [6:0] crc7(input bq_t m);
    bit d[$];
    bit [7:0] p;
    bit [6:0] r;
    p = 8'h89;
    d = m;
    for (int i = 0; i < 7; i++) d.push_back(1'b0);
    for (int i = 0; i < m.size(); i++)
      if (d[i])
        for (int j = 0; j < 8; j++) d[i+j] ^= p[7-j];
    for (int k = 0; k < 7; k++) r[6-k] = d[m.size()+k];
    return r;
  endfunction

  // monitor
  int   n = 0, last_rise = -100, en_n = -100, rises = 0;
  logic s_prev = 1'b0, busy_prev = 1'b0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    n++;
    if (i_en) begin
      en_n  = n;
      rises = 0;
    end else if (sdio_clk && !s_prev) begin
      rises++;
    end
    if (sdio_clk && !s_prev) last_rise = n;
    s_prev = sdio_clk;
    if (o_done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected actual=1 required=0");
      end else begin
        e = q.pop_front();
        chk("timeout", o_timeout, e.to);
        chk("crc_err", o_crc_err, e.ce);
        chk("frame_err", o_frame_err, e.fe);
        chk("busy_at_done", o_busy, 0);
        chk("busy_before_done", busy_prev, 1);
        if (e.chk_idx) chk("resp_idx", o_resp_idx, e.idx);
        if (e.chk_arg) chk("resp_arg", o_resp_arg, e.arg);
        if (e.chk_r2) chk("resp_r2", o_resp_r2, e.r2);
        case (e.kind)
          0: chk("lat_none", n - en_n, 2);
          1: chk("lat_frame", n - last_rise, 2);
          default: begin
            chk("timeout_rises", rises, 64);
            chk("lat_timeout", n - last_rise, 1);
          end
        endcase
      end
    end
    busy_prev = o_busy;
  end

  task automatic issue(input logic [1:0] t);
    @(posedge clk);
    #1 i_en = 1'b1;
    i_resp_type = t;
    @(posedge clk);
    #1 i_en = 1'b0;
  endtask

  task automatic send(input bq_t fr, input int idle, input int limit);
    repeat (idle) @(negedge sdio_clk);
    for (int i = 0; i < fr.size() && i < limit; i++) begin
      @(negedge sdio_clk);
      sdio_cmd_i = fr[i];
    end
    @(negedge sdio_clk);
    sdio_cmd_i = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (k < 800) begin
      @(negedge clk);
      if (o_done) break;
      k++;
    end
    if (k >= 800) begin
      checks++;
      failures++;
      $display("FAIL %s_no_done actual=0 required=1", name);
    end
  endtask

  function automatic bq_t build(input logic [1:0] t, input bit [5:0] idx,
      input bit [31:0] arg, input bit [119:0] r2, input bit tx,
      input bit [6:0] crcv, input bit endb, output bit [6:0] good);
    bq_t c, fr;
    bit [39:0] h;
    h = {1'b0, tx, idx, arg};
    if (t == 2'd3) begin
      for (int i = 119; i >= 0; i--) c.push_back(r2[i]);
      fr.push_back(1'b0);
      fr.push_back(tx);
      for (int i = 0; i < 6; i++) fr.push_back(1'b1);
      fr = {fr, c};
    end else begin
      for (int i = 39; i >= 0; i--) c.push_back(h[i]);
      fr = c;
    end
    good = crc7(c);
    return fr;
  endfunction

  task automatic frame_case(input logic [1:0] t, input bit [5:0] idx,
      input bit [31:0] arg, input bit [119:0] r2, input bit tx,
      input bit [6:0] flip, input bit endb, input bit use_f,
      input bit [6:0] forced, input int idle, input int limit,
      input bit expect_done);
    bq_t fr;
    bit [6:0] good, sent;
    exp_t e;
    fr = build(t, idx, arg, r2, tx, 7'd0, endb, good);
    sent = use_f ? forced : (good ^ flip);
    for (int i = 6; i >= 0; i--) fr.push_back(sent[i]);
    fr.push_back(endb);
    e.kind = 1;
    e.to = 1'b0;
    e.ce = (t != 2'd2) && (sent != good);
    e.fe = tx | ~endb;
    e.chk_idx = 1'b1;
    e.idx = (t == 2'd3) ? 6'h3F : idx;
    e.chk_arg = (t != 2'd3);
    e.arg = arg;
    e.chk_r2 = (t == 2'd3);
    e.r2 = r2;
    if (expect_done) q.push_back(e);
    issue(t);
    send(fr, idle, limit);
    if (expect_done) wait_done("frame");
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_flags", {o_timeout, o_crc_err, o_frame_err}, 0);
    chk("rst_idx", o_resp_idx, 0);
    chk("rst_arg", o_resp_arg, 0);
    chk("rst_r2", o_resp_r2, 0);
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // directed
    frame_case(1, 6'd8, 32'h1AA, '0, 0, 7'h00, 1, 0, 0, 5, 999, 1);
    frame_case(1, 6'd8, 32'h1AA, '0, 0, 7'h01, 1, 0, 0, 5, 999, 1);
    e = '{kind: 2, to: 1, default: '0};
    q.push_back(e);
    issue(1);
    wait_done("timeout");
    frame_case(3, 6'd0, 32'd0,
               120'h00_2600_325B_5A83_AFFF_FFFF_8000_0A40,
               0, 7'h00, 1, 0, 0, 3, 999, 1);
    frame_case(2, 6'h3F, 32'h80FF8000, '0, 0, 7'h00, 1, 1, 7'h7F,
               2, 999, 1);
    frame_case(2, 6'h3F, 32'h80FF8000, '0, 0, 7'h00, 0, 1, 7'h7F,
               2, 999, 1);
    e = '{kind: 0, default: '0};
    q.push_back(e);
    issue(0);
    wait_done("type0");

    // reset during RECV, then a fresh request
    frame_case(1, 6'd17, 32'hDEADBEEF, '0, 0, 7'h00, 1, 0, 0, 2, 20, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    frame_case(1, 6'd55, 32'h12345678, '0, 0, 7'h00, 1, 0, 0, 1, 999, 1);

    // randomized
    for (int it = 0; it < 24; it++) begin
      logic [1:0] t;
      bit [6:0] fl;
      t = 2'($urandom_range(1, 3));
      fl = ($urandom_range(0, 3) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'd0;
      frame_case(t, 6'($urandom), $urandom,
                 {24'($urandom), $urandom, $urandom, $urandom},
                 $urandom_range(0, 7) == 0, fl,
                 $urandom_range(0, 7) != 0, t == 2'd2, 7'($urandom),
                 $urandom_range(0, 10), 999, 1);
    end

    repeat (10) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
